camera_capture_pack: RTL and testbench
======================================

Name: camera_capture_pack

Overview:
Parametrised DVP camera front end. It synchronises to whole frames, assembles 8-bit sensor bytes into RGB565 or RAW8 pixels, and packs those pixels into OUT_W-bit words for the DDR write FIFO. It checks line and frame geometry, flags FIFO overflow, and holds frame_complete until the downstream frame-buffer swap acknowledges it. It sits between the sensor pins (camera_pclk domain) and the DDR write FIFO.

Parameters:
IMG_W, 640, active pixels per line
IMG_H, 480, active lines per frame
OUT_W, 64, output word width; multiple of 16, max 128
VSYNC_POL, 1, active level of camera_vsync
HREF_POL, 1, active level of camera_href

Ports:
camera_pclk  in  1  pixel clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
cap_en  in  1  capture enable; sampled only when leaving IDLE/DONE
fmt  in  1  0 = RGB565 (2 bytes/pixel), 1 = RAW8 (1 byte/pixel); latched at SYNC entry
fifo_ready  in  1  downstream FIFO can accept a word
frame_ack  in  1  frame buffer swap done (change_complete)
camera_href  in  1  line valid
camera_vsync  in  1  frame sync
camera_data  in  8  sensor byte
out_data  out  OUT_W  packed word; first byte received in MSBs
out_wren  out  1  one-cycle write strobe
out_sof  out  1  with out_wren on the first word of a frame
out_eol  out  1  with out_wren on the last word of each line
frame_complete  out  1  level; full frame delivered
frame_err  out  1  level; frame aborted
err_code  out  2  0 none, 1 short/long line, 2 short frame, 3 FIFO overflow
line_cnt  out  clog2(IMG_H+1)  lines completed in the current frame

Behaviour:
- Reset values: all outputs 0; state IDLE.
- BPL (bytes per line) = IMG_W*(fmt?1:2). Elaboration error if IMG_W*2 or IMG_W is not a multiple of OUT_W/8.
- States and transitions:
  - IDLE -> SYNC when cap_en && fifo_ready && vsync active.
  - SYNC: clears counters, frame_err and err_code; latches fmt. Goes to CAPTURE on vsync inactive.
  - CAPTURE: each href-active pclk stores one byte into the pack register (MSB first) and increments byte_cnt.
    - When the byte count reaches OUT_W/8: out_data is registered, and out_wren pulses the next cycle (1-cycle latency).
    - At href deassert: byte_cnt must equal BPL, else err 1 -> ERROR; any partial word is discarded. On a good line, line_cnt increments.
    - line_cnt reaching IMG_H -> DONE, and frame_complete=1 in the same cycle as the final out_wren.
    - vsync active before DONE -> err 2 -> ERROR.
    - out_wren with fifo_ready low -> the word is still strobed, err 3 -> ERROR.
    - href active outside SYNC/CAPTURE is ignored.
  - DONE: extra href lines are ignored. On frame_ack && vsync active, frame_complete clears and the block goes to SYNC if cap_en && fifo_ready, else IDLE. An ack arriving with vsync inactive is held (sticky) until vsync.
  - ERROR: frame_err=1 and no writes. Next vsync active -> IDLE (frame_err and err_code persist until SYNC).
- Simultaneous events:
  - Line-length error and overflow in the same cycle: err 3 wins.
  - Last word and vsync in the same cycle: DONE wins.
- Asynchronous reset mid-frame returns the block to IDLE. The next capture starts only at a fresh vsync, never mid-frame.

Decomposition:
- Package camera_pkg:
  - state enum (IDLE, SYNC, CAPTURE, DONE, ERROR)
  - err_code constants (ERR_NONE, ERR_LINE, ERR_FRAME, ERR_OVF)
  - fmt constants (FMT_RGB565, FMT_RAW8)
- Sub-module byte_packer: shift-in register, byte counter, word strobe, and a flush/clear input. The frame FSM and geometry checks stay in the top level.

Test Plan:
- Parameters IMG_W=4, IMG_H=2, OUT_W=32. RGB565, two good lines of bytes 0x11..0x18 each -> words 0x11121314 (sof=1) and 0x15161718 (eol=1) per line, 4 strobes total, frame_complete rises with the 4th.
- RAW8, same geometry, 4 bytes 0xA0..0xA3 per line -> one word 0xA0A1A2A3 per line with sof/eol set as appropriate; line_cnt=2; DONE.
- RGB565, second line only 6 bytes -> err_code=1, frame_err=1, no 4th strobe; after next vsync, re-arm and a clean frame succeeds.
- vsync asserted after 1 line -> err_code=2. fifo_ready low at the 2nd strobe -> err_code=3.
- In DONE, pulse frame_ack with vsync low then raise vsync -> frame_complete clears at vsync; next frame captured with sof on its first word.
- Assert rst mid-line -> all outputs 0 immediately; data before the next vsync produces no out_wren.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and constants for the DVP capture front end.
package camera_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LINE  = 2'd1;
    localparam logic [1:0] ERR_FRAME = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    localparam logic FMT_RGB565 = 1'b0;
    localparam logic FMT_RAW8   = 1'b1;

endpackage

// File: rtl/camera_capture_pack_if.sv
// Write-side bus from the capture block into the DDR write FIFO.
// out_wren is a one-cycle strobe carrying out_data/out_sof/out_eol; the FIFO
// must hold fifo_ready high in every strobe cycle, a strobe seen with
// fifo_ready low is still issued but counts as an overflow.
interface camera_capture_pack_if #(
    parameter int OUT_W = 64
);
    logic [OUT_W-1:0] out_data;
    logic             out_wren;
    logic             out_sof;
    logic             out_eol;
    logic             fifo_ready;

    modport master (output out_data, out_wren, out_sof, out_eol, input fifo_ready);
    modport slave  (input out_data, out_wren, out_sof, out_eol, output fifo_ready);
endinterface

// File: rtl/camera_capture_pack_byte_packer.sv
// Shifts sensor bytes MSB-first into an OUT_W word and strobes the word
// out one cycle after its last byte arrives.
module byte_packer #(
    parameter int OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             flush,
    input  logic [7:0]       byte_in,
    output logic             word_done,
    output logic [OUT_W-1:0] word,
    output logic             word_wr
);
    localparam int BPW  = OUT_W / 8;
    localparam int CW   = $clog2(BPW);
    localparam int SH_W = OUT_W - 8;

    logic [SH_W-1:0] sh_q;
    logic [CW-1:0]   cnt_q;

    assign word_done = shift_en && !flush && (cnt_q == CW'(BPW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            word    <= '0;
            word_wr <= 1'b0;
        end else begin
            word_wr <= 1'b0;
            if (flush) begin
                cnt_q <= '0;
            end else if (shift_en) begin
                if (word_done) begin
                    word    <= {sh_q, byte_in};
                    word_wr <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    // oldest byte drops off the top once the word is full
                    sh_q  <= SH_W'({sh_q, byte_in});
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/camera_capture_pack.sv
// DVP capture: frame sync FSM, line/frame geometry checks and pixel-to-word
// packing toward the DDR write FIFO.
module camera_capture_pack
    import camera_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int OUT_W     = 64,
    parameter bit VSYNC_POL = 1'b1,
    parameter bit HREF_POL  = 1'b1
) (
    input  logic                         camera_pclk,
    input  logic                         rst,
    input  logic                         cap_en,
    input  logic                         fmt,
    input  logic                         frame_ack,
    input  logic                         camera_href,
    input  logic                         camera_vsync,
    input  logic [7:0]                   camera_data,
    camera_capture_pack_if.master        fifo,
    output logic                         frame_complete,
    output logic                         frame_err,
    output logic [1:0]                   err_code,
    output logic [$clog2(IMG_H+1)-1:0]   line_cnt,
    output state_t                       state_dbg
);
    localparam int BPW  = OUT_W / 8;
    localparam int LC_W = $clog2(IMG_H + 1);
    localparam int LB_W = $clog2(2 * IMG_W + 2);

    if ((OUT_W % 16) != 0 || OUT_W > 128 || (IMG_W % BPW) != 0 || ((2 * IMG_W) % BPW) != 0) begin : g_bad_geometry
        $error("camera_capture_pack: IMG_W/OUT_W combination cannot pack whole lines");
    end

    state_t            state_q, state_d;
    logic              fmt_q, first_q, ack_pend_q, sof_q, eol_q, fc_q, err_q;
    logic [1:0]        err_code_q;
    logic [LC_W-1:0]   line_cnt_q;
    logic [LB_W-1:0]   line_bytes_q, bpl;
    logic              vs_act, hr_act, ovf, line_open, byte_ok, last_byte, final_word;
    logic              line_end, line_bad, shift_en, flush, word_done, pk_wr;
    logic [OUT_W-1:0]  pk_word;

    assign vs_act     = (camera_vsync == VSYNC_POL);
    assign hr_act     = (camera_href == HREF_POL);
    assign bpl        = (fmt_q == FMT_RAW8) ? LB_W'(IMG_W) : LB_W'(2 * IMG_W);
    assign ovf        = pk_wr && !fifo.fifo_ready;
    assign line_open  = (line_bytes_q != '0);
    assign byte_ok    = hr_act && (line_bytes_q < bpl);
    assign last_byte  = byte_ok && (line_bytes_q == bpl - LB_W'(1));
    assign final_word = last_byte && (line_cnt_q == LC_W'(IMG_H - 1));
    assign line_end   = !hr_act && line_open;
    assign line_bad   = line_end && (line_bytes_q != bpl);

    always_ff @(posedge camera_pclk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Priority inside CAPTURE: overflow, then finishing the frame, then
    // early vsync, then a bad line length.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_en && fifo.fifo_ready && vs_act) state_d = SYNC;
            SYNC:    if (!vs_act) state_d = CAPTURE;
            CAPTURE: begin
                if (ovf)             state_d = ERROR;
                else if (final_word) state_d = DONE;
                else if (vs_act)     state_d = ERROR;
                else if (line_bad)   state_d = ERROR;
            end
            DONE: begin
                if (ovf) state_d = ERROR;
                else if ((frame_ack || ack_pend_q) && vs_act)
                    state_d = (cap_en && fifo.fifo_ready) ? SYNC : IDLE;
            end
            ERROR:   if (vs_act) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        flush    = 1'b1;
        if (state_q == CAPTURE) begin
            flush    = line_end;
            shift_en = byte_ok && (state_d != ERROR);
        end
    end

    always_ff @(posedge camera_pclk or posedge rst) begin
        if (rst) begin
            fmt_q        <= FMT_RGB565;
            first_q      <= 1'b0;
            ack_pend_q   <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            fc_q         <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            line_cnt_q   <= '0;
            line_bytes_q <= '0;
        end else begin
            sof_q <= 1'b0;
            eol_q <= 1'b0;
            if (state_d == SYNC && state_q != SYNC) begin
                fmt_q        <= fmt;
                first_q      <= 1'b1;
                ack_pend_q   <= 1'b0;
                fc_q         <= 1'b0;
                err_q        <= 1'b0;
                err_code_q   <= ERR_NONE;
                line_cnt_q   <= '0;
                line_bytes_q <= '0;
            end
            if (state_q == CAPTURE) begin
                if (shift_en) begin
                    line_bytes_q <= line_bytes_q + LB_W'(1);
                    sof_q        <= word_done && first_q;
                    eol_q        <= last_byte;
                    if (word_done) first_q <= 1'b0;
                    // the last line is counted on its final byte so the
                    // completion flag lines up with the final strobe
                    if (final_word) begin
                        line_cnt_q <= line_cnt_q + LC_W'(1);
                        fc_q       <= 1'b1;
                    end
                end else if (hr_act && line_bytes_q == bpl) begin
                    line_bytes_q <= bpl + LB_W'(1);
                end else if (line_end && !line_bad && state_d == CAPTURE) begin
                    line_cnt_q   <= line_cnt_q + LC_W'(1);
                    line_bytes_q <= '0;
                end
            end
            if (state_q == DONE) begin
                ack_pend_q <= ack_pend_q | frame_ack;
                if (state_d != DONE) begin
                    fc_q       <= 1'b0;
                    ack_pend_q <= 1'b0;
                end
            end
            if (state_d == ERROR && state_q != ERROR) begin
                err_q      <= 1'b1;
                fc_q       <= 1'b0;
                err_code_q <= ovf ? ERR_OVF : (vs_act ? ERR_FRAME : ERR_LINE);
            end
        end
    end

    byte_packer #(.OUT_W(OUT_W)) u_packer (
        .clk       (camera_pclk),
        .rst       (rst),
        .shift_en  (shift_en),
        .flush     (flush),
        .byte_in   (camera_data),
        .word_done (word_done),
        .word      (pk_word),
        .word_wr   (pk_wr)
    );

    assign fifo.out_data   = pk_word;
    assign fifo.out_wren   = pk_wr;
    assign fifo.out_sof    = sof_q;
    assign fifo.out_eol    = eol_q;
    assign frame_complete  = fc_q;
    assign frame_err       = err_q;
    assign err_code        = err_code_q;
    assign line_cnt        = line_cnt_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_camera_capture_pack.sv
// Bench for camera_capture_pack with a 4x2 image packed into 32-bit words.
module tb_camera_capture_pack;
    import camera_pkg::*;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int OUT_W = 32;
    localparam int BPW   = OUT_W / 8;
    localparam int LC_W  = $clog2(IMG_H + 1);
    localparam int SB_W  = OUT_W + 3;

    logic            camera_pclk = 1'b0;
    logic            rst, cap_en, fmt, frame_ack, camera_href, camera_vsync;
    logic [7:0]      camera_data;
    logic            frame_complete, frame_err;
    logic [1:0]      err_code;
    logic [LC_W-1:0] line_cnt;
    state_t          state_dbg;

    camera_capture_pack_if #(.OUT_W(OUT_W)) fifo_bus ();

    camera_capture_pack #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W), .VSYNC_POL(1'b1), .HREF_POL(1'b1)
    ) dut (
        .camera_pclk    (camera_pclk),
        .rst            (rst),
        .cap_en         (cap_en),
        .fmt            (fmt),
        .frame_ack      (frame_ack),
        .camera_href    (camera_href),
        .camera_vsync   (camera_vsync),
        .camera_data    (camera_data),
        .fifo           (fifo_bus),
        .frame_complete (frame_complete),
        .frame_err      (frame_err),
        .err_code       (err_code),
        .line_cnt       (line_cnt),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    always #5 camera_pclk = ~camera_pclk;

    // scoreboard entry: {frame_complete, sof, eol, data}
    logic [SB_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cur_bpl  = 2 * IMG_W;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge camera_pclk) begin
        if (fifo_bus.out_wren) begin
            if (exp_q.size() == 0)
                check("unexp_wr", 64'(fifo_bus.out_wren), 64'd0);
            else
                check("word", 64'({frame_complete, fifo_bus.out_sof, fifo_bus.out_eol, fifo_bus.out_data}),
                      64'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge camera_pclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vsync_pulse();
        camera_vsync = 1'b1;
        idle(3);
        camera_vsync = 1'b0;
        idle(2);
    endtask

    // Reference model for one line: only whole words inside the nominal
    // line length are written; eol on the word that closes the line.
    task automatic expect_line(input int n, input logic [7:0] base, input bit first, input bit last);
        int               full;
        logic [OUT_W-1:0] word;
        bit               eol;
        full = (n < cur_bpl) ? n : cur_bpl;
        for (int w = 0; BPW * (w + 1) <= full; w++) begin
            word = '0;
            for (int k = 0; k < BPW; k++)
                word = {word[OUT_W-9:0], 8'(base + 8'(BPW * w + k))};
            eol = (BPW * (w + 1) == cur_bpl);
            exp_q.push_back({last && eol, first && (w == 0), eol, word});
        end
    endtask

    task automatic drive_line(input int n, input logic [7:0] base, input int drop_at);
        camera_href = 1'b1;
        for (int i = 0; i < n; i++) begin
            camera_data = base + 8'(i);
            if (i == drop_at) fifo_bus.fifo_ready = 1'b0;
            tick();
        end
        camera_href = 1'b0;
        camera_data = 8'h00;
        idle(3);
    endtask

    task automatic good_frame(input logic [7:0] b0, input logic [7:0] b1);
        expect_line(cur_bpl, b0, 1'b1, 1'b0);
        drive_line(cur_bpl, b0, -1);
        expect_line(cur_bpl, b1, 1'b0, 1'b1);
        drive_line(cur_bpl, b1, -1);
    endtask

    initial begin
        rst = 1'b1; cap_en = 1'b0; fmt = FMT_RGB565; frame_ack = 1'b0;
        camera_href = 1'b0; camera_vsync = 1'b0; camera_data = 8'h00;
        fifo_bus.fifo_ready = 1'b1;
        idle(2);
        check("rst_wren",  64'(fifo_bus.out_wren), 64'd0);
        check("rst_data",  64'(fifo_bus.out_data), 64'd0);
        check("rst_fc",    64'(frame_complete), 64'd0);
        check("rst_ferr",  64'(frame_err), 64'd0);
        check("rst_err",   64'(err_code), 64'd0);
        check("rst_lines", 64'(line_cnt), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        rst = 1'b0;
        idle(2);

        // RGB565 good frame
        cap_en = 1'b1;
        cur_bpl = 2 * IMG_W;
        vsync_pulse();
        good_frame(8'h11, 8'h11);
        check("rgb_fc",    64'(frame_complete), 64'd1);
        check("rgb_lines", 64'(line_cnt), 64'd2);
        check("rgb_state", 64'(state_dbg), 64'(DONE));
        check("rgb_sb",    64'(exp_q.size()), 64'd0);

        // extra line in DONE is ignored; ack with vsync low is held
        drive_line(8, 8'h55, -1);
        check("done_lines", 64'(line_cnt), 64'd2);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        idle(2);
        check("ack_hold_fc",    64'(frame_complete), 64'd1);
        check("ack_hold_state", 64'(state_dbg), 64'(DONE));
        fmt = FMT_RAW8;
        camera_vsync = 1'b1;
        tick();
        check("ack_vs_fc",    64'(frame_complete), 64'd0);
        check("ack_vs_state", 64'(state_dbg), 64'(SYNC));
        idle(2);
        camera_vsync = 1'b0;
        idle(2);

        // RAW8 frame
        cur_bpl = IMG_W;
        good_frame(8'hA0, 8'hA0);
        check("raw_fc",    64'(frame_complete), 64'd1);
        check("raw_lines", 64'(line_cnt), 64'd2);
        check("raw_state", 64'(state_dbg), 64'(DONE));

        // short second line
        fmt = FMT_RGB565;
        cur_bpl = 2 * IMG_W;
        frame_ack = 1'b1;
        vsync_pulse();
        frame_ack = 1'b0;
        expect_line(8, 8'h11, 1'b1, 1'b0);
        drive_line(8, 8'h11, -1);
        expect_line(6, 8'h11, 1'b0, 1'b0);
        drive_line(6, 8'h11, -1);
        check("short_err",   64'(err_code), 64'(ERR_LINE));
        check("short_ferr",  64'(frame_err), 64'd1);
        check("short_state", 64'(state_dbg), 64'(ERROR));
        check("short_sb",    64'(exp_q.size()), 64'd0);
        vsync_pulse();
        check("rearm_ferr", 64'(frame_err), 64'd0);
        check("rearm_err",  64'(err_code), 64'(ERR_NONE));
        good_frame(8'h21, 8'h29);
        check("rearm_fc", 64'(frame_complete), 64'd1);

        // vsync after one line
        frame_ack = 1'b1;
        vsync_pulse();
        frame_ack = 1'b0;
        expect_line(8, 8'h31, 1'b1, 1'b0);
        drive_line(8, 8'h31, -1);
        camera_vsync = 1'b1;
        tick();
        check("frm_err",   64'(err_code), 64'(ERR_FRAME));
        check("frm_ferr",  64'(frame_err), 64'd1);
        check("frm_lines", 64'(line_cnt), 64'd1);
        idle(2);
        camera_vsync = 1'b0;
        idle(2);
        check("frm_restart", 64'(state_dbg), 64'(CAPTURE));

        // fifo_ready low at the second strobe
        expect_line(8, 8'h41, 1'b1, 1'b0);
        drive_line(8, 8'h41, 7);
        fifo_bus.fifo_ready = 1'b1;
        check("ovf_err",   64'(err_code), 64'(ERR_OVF));
        check("ovf_state", 64'(state_dbg), 64'(ERROR));
        drive_line(8, 8'h51, -1);
        check("ovf_ferr", 64'(frame_err), 64'd1);

        // reset in the middle of a line
        vsync_pulse();
        expect_line(8, 8'h61, 1'b1, 1'b0);
        drive_line(8, 8'h61, -1);
        camera_href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            camera_data = 8'h69 + 8'(i);
            tick();
        end
        rst = 1'b1;
        #1;
        check("mrst_data",  64'(fifo_bus.out_data), 64'd0);
        check("mrst_wren",  64'(fifo_bus.out_wren), 64'd0);
        check("mrst_lines", 64'(line_cnt), 64'd0);
        check("mrst_state", 64'(state_dbg), 64'(IDLE));
        camera_href = 1'b0;
        tick();
        rst = 1'b0;
        drive_line(8, 8'h71, -1);
        drive_line(8, 8'h79, -1);
        check("mrst_idle", 64'(state_dbg), 64'(IDLE));
        vsync_pulse();
        good_frame(8'h81, 8'h91);
        check("mrst_fc", 64'(frame_complete), 64'd1);

        idle(2);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
